// File: rtl/fmm_reduce_pkg.sv
// Shared constants, FSM state encoding and M_e port bundle for the reduce-kernel blocks.
package fmm_reduce_pkg;

  localparam int ROW_STRIDE = 320;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              ce;
    logic              we;
    logic [DATA_W-1:0] d;
  } me_port_t;

endpackage

// File: rtl/fmm_reduce_kernel_row_addr_gen.sv
// Row counter plus row-stride address accumulator; flags the final row of a column scan.
module fmm_reduce_kernel_row_addr_gen
  import fmm_reduce_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] col,
  input  logic [31:0]       rowt_q,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       row,
  output logic              last
);

  // Accumulating by the stride avoids a multiplier; the add wraps modulo 2^ADDR_W by width.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      row  <= '0;
      addr <= '0;
    end else if (load) begin
      row  <= '0;
      addr <= col;
    end else if (advance) begin
      row  <= row + 32'd1;
      addr <= addr + ADDR_W'(ROW_STRIDE);
    end
  end

  assign last = (row + 32'd1) == rowt_q;

endmodule

// File: rtl/fmm_reduce_kernel_column_unit_writer.sv
// Writes a unit column (1 at pivot_row, 0 elsewhere) into M_e under ap_ctrl_hs control.
// Optional FMM_COLW_BACKPRESSURE_EN adds M_e_wready; a RUN write commits only when it is high.
module fmm_reduce_kernel_column_unit_writer
  import fmm_reduce_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [31:0]       rowt,
  input  logic [ADDR_W-1:0] col,
  input  logic [31:0]       pivot_row,
  output logic [ADDR_W-1:0] M_e_address0,
  output logic              M_e_ce0,
  output logic              M_e_we0,
  output logic [DATA_W-1:0] M_e_d0,
  output logic [31:0]       rows_written,
  output logic              rows_written_ap_vld,
  output logic              pivot_hit
`ifdef FMM_COLW_BACKPRESSURE_EN
  ,
  input  logic              M_e_wready
`endif
);

  state_t            state;
  logic [31:0]       rowt_q;
  logic [31:0]       pivot_q;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       row;
  logic              last;
  logic              load;
  logic              commit;
  me_port_t          me;

  assign load = (state == S_IDLE) && ap_start;

`ifdef FMM_COLW_BACKPRESSURE_EN
  assign commit = (state == S_RUN) && M_e_wready;
`else
  assign commit = (state == S_RUN);
`endif

  fmm_reduce_kernel_row_addr_gen u_addr_gen (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .load    (load),
    .advance (commit),
    .col     (col),
    .rowt_q  (rowt_q),
    .addr    (addr),
    .row     (row),
    .last    (last)
  );

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state               <= S_IDLE;
      rowt_q              <= '0;
      pivot_q             <= '0;
      ap_done             <= 1'b0;
      ap_ready            <= 1'b0;
      rows_written_ap_vld <= 1'b0;
      rows_written        <= '0;
      pivot_hit           <= 1'b0;
    end else begin
      ap_done             <= 1'b0;
      ap_ready            <= 1'b0;
      rows_written_ap_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            rowt_q    <= rowt;
            pivot_q   <= pivot_row;
            pivot_hit <= 1'b0;
            state     <= ($signed(rowt) > 0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (commit && last) state <= S_DONE;
        end
        S_DONE: begin
          ap_done             <= 1'b1;
          ap_ready            <= 1'b1;
          rows_written_ap_vld <= 1'b1;
          rows_written        <= row;
          pivot_hit           <= ($signed(pivot_q) >= 0) && ($signed(pivot_q) < $signed(rowt_q));
          state               <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write strobes are decoded from the state register only; stalled writes simply persist.
  assign me.address = addr;
  assign me.ce      = (state == S_RUN);
  assign me.we      = (state == S_RUN);
  assign me.d       = (row == pivot_q) ? DATA_W'(1) : '0;

  assign M_e_address0 = me.address;
  assign M_e_ce0      = me.ce;
  assign M_e_we0      = me.we;
  assign M_e_d0       = me.d;
  assign ap_idle      = (state == S_IDLE);

endmodule

// File: tb/tb_fmm_reduce_kernel_column_unit_writer.sv
// Scoreboard bench for the unit-column writer; expected writes are queued at start and popped on commit.
module tb_fmm_reduce_kernel_column_unit_writer;
  import fmm_reduce_pkg::*;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              ap_start = 1'b0;
  logic              ap_done, ap_idle, ap_ready;
  logic [31:0]       rowt = '0;
  logic [ADDR_W-1:0] col = '0;
  logic [31:0]       pivot_row = '0;
  logic [ADDR_W-1:0] M_e_address0;
  logic              M_e_ce0, M_e_we0;
  logic [DATA_W-1:0] M_e_d0;
  logic [31:0]       rows_written;
  logic              rows_written_ap_vld;
  logic              pivot_hit;
`ifdef FMM_COLW_BACKPRESSURE_EN
  logic              M_e_wready = 1'b1;
`endif

  always #5 ap_clk = ~ap_clk;

  fmm_reduce_kernel_column_unit_writer dut (
    .ap_clk              (ap_clk),
    .ap_rst              (ap_rst),
    .ap_start            (ap_start),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .ap_ready            (ap_ready),
    .rowt                (rowt),
    .col                 (col),
    .pivot_row           (pivot_row),
    .M_e_address0        (M_e_address0),
    .M_e_ce0             (M_e_ce0),
    .M_e_we0             (M_e_we0),
    .M_e_d0              (M_e_d0),
    .rows_written        (rows_written),
    .rows_written_ap_vld (rows_written_ap_vld),
    .pivot_hit           (pivot_hit)
`ifdef FMM_COLW_BACKPRESSURE_EN
    ,
    .M_e_wready          (M_e_wready)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one job; stall_lo..stall_hi are RUN-relative cycles with wready low, rst_at > 0 resets mid-run.
  task automatic run_job(input int rt, input int c, input int pv,
                         input int stall_lo, input int stall_hi, input int rst_at);
    int   rtp;
    int   stalls;
    int   k;
    int   limit;
    bit   done_seen;
    bit   hit;
    logic wr_ok;
    wr_t  w;
    rtp    = (rt > 0) ? rt : 0;
    hit    = (pv >= 0) && (pv < rt);
    stalls = 0;
    limit  = rtp + 40;
    done_seen = 1'b0;
    @(negedge ap_clk);
    rowt      = rt;
    col       = ADDR_W'(c);
    pivot_row = pv;
    ap_start  = 1'b1;
    for (int r = 0; r < rt; r++) begin
      w.addr = ADDR_W'((r * ROW_STRIDE + c) % (1 << ADDR_W));
      w.data = (r == pv) ? DATA_W'(1) : DATA_W'(0);
      exp_q.push_back(w);
    end
    @(posedge ap_clk);
    #1;
    ap_start  = 1'b0;
    rowt      = $urandom;
    col       = ADDR_W'($urandom);
    pivot_row = $urandom;
    k = 0;
    while (!done_seen && k < limit) begin
      k++;
      @(negedge ap_clk);
      wr_ok = 1'b1;
`ifdef FMM_COLW_BACKPRESSURE_EN
      M_e_wready = !(k >= stall_lo && k <= stall_hi);
      wr_ok      = M_e_wready;
`endif
      if (M_e_ce0 === 1'b1 || M_e_we0 === 1'b1) begin
        check("wr_known", 64'($isunknown({M_e_address0, M_e_d0})), 64'd0);
        check("wr_ce_we", {M_e_ce0, M_e_we0}, 2'b11);
        if (exp_q.size() == 0) begin
          check("wr_extra", 64'd1, 64'd0);
        end else begin
          check("wr_addr", M_e_address0, exp_q[0].addr);
          check("wr_data", M_e_d0, exp_q[0].data);
          if (wr_ok) void'(exp_q.pop_front());
          else stalls++;
        end
      end
      if (ap_done === 1'b1) begin
        done_seen = 1'b1;
        check("done_latency", k, rtp + 2 + stalls);
        check("ap_ready", ap_ready, 1'b1);
        check("rows_vld", rows_written_ap_vld, 1'b1);
        check("rows_written", rows_written, rtp);
        check("pivot_hit", pivot_hit, hit);
        check("all_written", exp_q.size(), 0);
      end
      if (k == rst_at) begin
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check("rst_ce", M_e_ce0, 1'b0);
        check("rst_we", M_e_we0, 1'b0);
        check("rst_idle", ap_idle, 1'b1);
        check("rst_done", ap_done, 1'b0);
        repeat (3) begin
          @(negedge ap_clk);
          check("rst_no_done", {ap_done, M_e_ce0}, 2'b00);
        end
        exp_q.delete();
        return;
      end
    end
`ifdef FMM_COLW_BACKPRESSURE_EN
    M_e_wready = 1'b1;
`endif
    if (!done_seen) check("done_timeout", 64'd0, 64'd1);
    @(negedge ap_clk);
    check("done_pulse", ap_done, 1'b0);
    check("idle_after", ap_idle, 1'b1);
    check("hit_holds", pivot_hit, hit);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge ap_clk);
    check("reset_idle", ap_idle, 1'b1);
    check("reset_strobes", {ap_done, ap_ready, M_e_ce0, M_e_we0, rows_written_ap_vld}, 5'b0);
    check("reset_rows", rows_written, 32'd0);
    check("reset_hit", pivot_hit, 1'b0);
    ap_rst = 1'b0;

    run_job(4, 5, 2, 0, -1, 0);
    run_job(0, 7, 0, 0, -1, 0);
    run_job(-3, 7, 0, 0, -1, 0);
    run_job(3, 9, 7, 0, -1, 0);
    run_job(3, 9, -1, 0, -1, 0);
    run_job(1, 0, 0, 0, -1, 0);
    run_job(420, 100, 419, 0, -1, 0);
    run_job(8, 20, 5, 0, -1, 3);
    run_job(2, 11, 1, 0, -1, 0);
`ifdef FMM_COLW_BACKPRESSURE_EN
    run_job(4, 5, 2, 2, 3, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
